// File: rtl/usart_frame_rx.sv
// rtl/usart_frame_rx.sv - 8N1 receiver assembling 5-byte command frames
//
// Samples uart_rxd through a two-flop synchroniser, deserialises 8N1 bytes
// and packs each 5-byte frame into Adress / Mod_SEL / D, pulsing trig when a
// frame is complete. Outputs only move on frame completion.
//
// Optional feature: define USART_RX_TIMEOUT_EN to build an inter-byte timer
// that abandons a partial frame after TIMEOUT_CNT idle clocks and pulses
// frame_err. Without the macro a partial frame waits indefinitely.

module usart_frame_rx #(
  parameter logic [15:0] BPS_CNT     = 16'd434
`ifdef USART_RX_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CNT = 32'd8680
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic        trig,
  output logic [23:0] D,
  output logic [1:0]  Adress,
  output logic [5:0]  Mod_SEL,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Start bit is checked half a period after the edge; afterwards the counter
  // restarts at the start-bit centre, so every later bit centre sits one full
  // period (BPS_CNT-1) further on.
  localparam logic [15:0] HALF_CNT = BPS_CNT >> 1;
  localparam logic [15:0] LAST_CNT = BPS_CNT - 16'd1;

  // Synchroniser and edge-detect flops (idle level is 1)
  logic        rxd_meta_q, rxd_meta_d;
  logic        rxd_sync_q, rxd_sync_d;
  logic        rxd_prev_q, rxd_prev_d;

  // Bit-level receiver
  state_t      state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  data_idx_q, data_idx_d;
  logic [7:0]  shift_q, shift_d;

  // Frame assembler shadows
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  adr_sh_q, adr_sh_d;
  logic [5:0]  mod_sh_q, mod_sh_d;
  logic [15:0] d_hi_sh_q, d_hi_sh_d;

  // Registered outputs
  logic        trig_q, trig_d;
  logic        frame_err_q, frame_err_d;
  logic [23:0] d_q, d_d;
  logic [1:0]  adress_q, adress_d;
  logic [5:0]  mod_sel_q, mod_sel_d;

`ifdef USART_RX_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
`endif

  // A stop bit sampled high in the current cycle
  logic        byte_valid;
  logic        fall_edge;

  assign fall_edge = rxd_prev_q & ~rxd_sync_q;

  // Next-state logic for synchroniser, bit FSM, frame assembler and timer
  always_comb begin
    rxd_meta_d  = uart_rxd;
    rxd_sync_d  = rxd_meta_q;
    rxd_prev_d  = rxd_sync_q;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_idx_d  = data_idx_q;
    shift_d     = shift_q;

    byte_idx_d  = byte_idx_q;
    adr_sh_d    = adr_sh_q;
    mod_sh_d    = mod_sh_q;
    d_hi_sh_d   = d_hi_sh_q;

    trig_d      = 1'b0;
    frame_err_d = 1'b0;
    d_d         = d_q;
    adress_d    = adress_q;
    mod_sel_d   = mod_sel_q;

    byte_valid  = 1'b0;

`ifdef USART_RX_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    unique case (state_q)
      IDLE: begin
        bit_cnt_d  = 16'd0;
        data_idx_d = 3'd0;
        if (fall_edge) begin
          state_d = START;
        end
      end

      START: begin
        if (bit_cnt_q == HALF_CNT) begin
          bit_cnt_d = 16'd0;
          // A line already back high at mid-start is a glitch, not a byte
          state_d   = rxd_sync_q ? IDLE : DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (bit_cnt_q == LAST_CNT) begin
          bit_cnt_d  = 16'd0;
          shift_d    = {rxd_sync_q, shift_q[7:1]};
          data_idx_d = data_idx_q + 3'd1;
          if (data_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (bit_cnt_q == LAST_CNT) begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          bit_cnt_d = 16'd0;
          state_d   = IDLE;
          if (rxd_sync_q) begin
            byte_valid = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            byte_idx_d  = 3'd0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = 16'd0;
      end
    endcase

    if (byte_valid) begin
      unique case (byte_idx_q)
        3'd0: begin
          adr_sh_d   = shift_q[1:0];
          byte_idx_d = 3'd1;
        end
        3'd1: begin
          mod_sh_d   = shift_q[5:0];
          byte_idx_d = 3'd2;
        end
        3'd2: begin
          d_hi_sh_d[15:8] = shift_q;
          byte_idx_d      = 3'd3;
        end
        3'd3: begin
          d_hi_sh_d[7:0] = shift_q;
          byte_idx_d     = 3'd4;
        end
        3'd4: begin
          // Last byte goes straight to the output so D is whole with trig
          d_d        = {d_hi_sh_q, shift_q};
          adress_d   = adr_sh_q;
          mod_sel_d  = mod_sh_q;
          trig_d     = 1'b1;
          byte_idx_d = 3'd0;
        end
        default: begin
          byte_idx_d = 3'd0;
        end
      endcase
    end

`ifdef USART_RX_TIMEOUT_EN
    // A received byte always beats an expiring timer
    if (byte_valid || (byte_idx_q == 3'd0)) begin
      timer_d = 32'd0;
    end else if (state_q == IDLE) begin
      if (timer_q == TIMEOUT_CNT) begin
        timer_d     = 32'd0;
        byte_idx_d  = 3'd0;
        frame_err_d = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
`endif
  end

  // State registers; reset clears everything, synchroniser idles high
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 16'd0;
      data_idx_q  <= 3'd0;
      shift_q     <= 8'd0;
      byte_idx_q  <= 3'd0;
      adr_sh_q    <= 2'd0;
      mod_sh_q    <= 6'd0;
      d_hi_sh_q   <= 16'd0;
      trig_q      <= 1'b0;
      frame_err_q <= 1'b0;
      d_q         <= 24'd0;
      adress_q    <= 2'd0;
      mod_sel_q   <= 6'd0;
`ifdef USART_RX_TIMEOUT_EN
      timer_q     <= 32'd0;
`endif
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxd_sync_q  <= rxd_sync_d;
      rxd_prev_q  <= rxd_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_idx_q  <= data_idx_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      adr_sh_q    <= adr_sh_d;
      mod_sh_q    <= mod_sh_d;
      d_hi_sh_q   <= d_hi_sh_d;
      trig_q      <= trig_d;
      frame_err_q <= frame_err_d;
      d_q         <= d_d;
      adress_q    <= adress_d;
      mod_sel_q   <= mod_sel_d;
`ifdef USART_RX_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign trig      = trig_q;
  assign frame_err = frame_err_q;
  assign D         = d_q;
  assign Adress    = adress_q;
  assign Mod_SEL   = mod_sel_q;

endmodule

// File: tb/tb_usart_frame_rx.sv
// tb/tb_usart_frame_rx.sv - directed bench for usart_frame_rx
`timescale 1ns/1ps

module tb_usart_frame_rx;

  localparam int BPS = 16;

  logic        sys_clk  = 1'b0;
  logic        sys_rst  = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        trig;
  logic [23:0] D;
  logic [1:0]  Adress;
  logic [5:0]  Mod_SEL;
  logic        frame_err;

  usart_frame_rx #(
    .BPS_CNT(16'd16)
`ifdef USART_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CNT(32'd320)
`endif
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .trig     (trig),
    .D        (D),
    .Adress   (Adress),
    .Mod_SEL  (Mod_SEL),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   trig_cnt  = 0;
  int   err_cnt   = 0;
  int   trig_wide = 0;
  logic trig_prev = 1'b0;
  logic [1:0]  q_adr[$];
  logic [5:0]  q_mod[$];
  logic [23:0] q_d[$];

  // Record trig pulses with the fields valid alongside them, and frame_err pulses
  always @(negedge sys_clk) begin
    if (trig === 1'b1) begin
      trig_cnt <= trig_cnt + 1;
      q_adr.push_back(Adress);
      q_mod.push_back(Mod_SEL);
      q_d.push_back(D);
      if (trig_prev === 1'b1) trig_wide <= trig_wide + 1;
    end
    trig_prev <= trig;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  function automatic logic [1:0] get_adr(input int i);
    if (i < q_adr.size()) return q_adr[i];
    return 2'bxx;
  endfunction

  function automatic logic [5:0] get_mod(input int i);
    if (i < q_mod.size()) return q_mod[i];
    return 6'bxxxxxx;
  endfunction

  function automatic logic [23:0] get_d(input int i);
    if (i < q_d.size()) return q_d[i];
    return 24'hxxxxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(BPS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(BPS);
    end
    uart_rxd = stop_bit;
    tick(BPS);
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) begin
      send_byte(f[i*8 +: 8], 1'b1);
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_checks++; if (trig !== 1'b0)      begin n_fail++; $display("FAIL reset_trig: got %0b expected 0", trig); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", frame_err); end
    n_checks++; if (D !== 24'h0)        begin n_fail++; $display("FAIL reset_d: got %06h expected 000000", D); end
    n_checks++; if (Adress !== 2'd0)    begin n_fail++; $display("FAIL reset_adr: got %0h expected 0", Adress); end
    n_checks++; if (Mod_SEL !== 6'd0)   begin n_fail++; $display("FAIL reset_mod: got %02h expected 00", Mod_SEL); end
    sys_rst = 1'b0;
    tick(20);
  endtask

  task automatic test_basic_frame;
    int bt, be;
    bt = trig_cnt; be = err_cnt;
    send_frame(40'h02_15_AB_CD_EF);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 1) begin n_fail++; $display("FAIL basic_trig_count: got %0d expected 1", trig_cnt - bt); end
    n_checks++; if (err_cnt - be !== 0)  begin n_fail++; $display("FAIL basic_err_count: got %0d expected 0", err_cnt - be); end
    n_checks++; if (get_adr(bt) !== 2'd2)     begin n_fail++; $display("FAIL basic_adr: got %0h expected 2", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h15)    begin n_fail++; $display("FAIL basic_mod: got %02h expected 15", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'hABCDEF) begin n_fail++; $display("FAIL basic_d: got %06h expected abcdef", get_d(bt)); end
    tick(20);
  endtask

  task automatic test_back_to_back;
    int bt;
    bt = trig_cnt;
    send_frame(40'hFF_FF_00_00_01);
    send_frame(40'h01_2A_12_34_56);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 2) begin n_fail++; $display("FAIL b2b_trig_count: got %0d expected 2", trig_cnt - bt); end
    n_checks++; if (get_adr(bt) !== 2'd3)       begin n_fail++; $display("FAIL b2b_adr0: got %0h expected 3", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h3F)      begin n_fail++; $display("FAIL b2b_mod0: got %02h expected 3f", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'h000001)   begin n_fail++; $display("FAIL b2b_d0: got %06h expected 000001", get_d(bt)); end
    n_checks++; if (get_adr(bt+1) !== 2'd1)     begin n_fail++; $display("FAIL b2b_adr1: got %0h expected 1", get_adr(bt+1)); end
    n_checks++; if (get_mod(bt+1) !== 6'h2A)    begin n_fail++; $display("FAIL b2b_mod1: got %02h expected 2a", get_mod(bt+1)); end
    n_checks++; if (get_d(bt+1) !== 24'h123456) begin n_fail++; $display("FAIL b2b_d1: got %06h expected 123456", get_d(bt+1)); end
    n_checks++; if (trig_wide !== 0) begin n_fail++; $display("FAIL trig_width: got %0d wide pulses expected 0", trig_wide); end
    tick(20);
  endtask

  task automatic test_stop_error;
    int bt, be;
    bt = trig_cnt; be = err_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    tick(20);
    n_checks++; if (err_cnt - be !== 1)  begin n_fail++; $display("FAIL stoperr_err_count: got %0d expected 1", err_cnt - be); end
    n_checks++; if (trig_cnt - bt !== 0) begin n_fail++; $display("FAIL stoperr_trig_count: got %0d expected 0", trig_cnt - bt); end
    n_checks++; if (D !== 24'h123456)    begin n_fail++; $display("FAIL stoperr_hold_d: got %06h expected 123456", D); end
    n_checks++; if (Mod_SEL !== 6'h2A)   begin n_fail++; $display("FAIL stoperr_hold_mod: got %02h expected 2a", Mod_SEL); end
    bt = trig_cnt;
    send_frame(40'h01_02_03_04_05);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 1)      begin n_fail++; $display("FAIL stoperr_next_trig: got %0d expected 1", trig_cnt - bt); end
    n_checks++; if (get_adr(bt) !== 2'd1)     begin n_fail++; $display("FAIL stoperr_next_adr: got %0h expected 1", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h02)    begin n_fail++; $display("FAIL stoperr_next_mod: got %02h expected 02", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'h030405) begin n_fail++; $display("FAIL stoperr_next_d: got %06h expected 030405", get_d(bt)); end
    tick(20);
  endtask

  task automatic test_start_glitch;
    int bt, be;
    bt = trig_cnt; be = err_cnt;
    uart_rxd = 1'b0;
    tick(5);
    uart_rxd = 1'b1;
    tick(40);
    n_checks++; if (trig_cnt - bt !== 0) begin n_fail++; $display("FAIL glitch_trig_count: got %0d expected 0", trig_cnt - bt); end
    n_checks++; if (err_cnt - be !== 0)  begin n_fail++; $display("FAIL glitch_err_count: got %0d expected 0", err_cnt - be); end
    send_frame(40'h02_3C_DE_AD_42);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 1)      begin n_fail++; $display("FAIL glitch_next_trig: got %0d expected 1", trig_cnt - bt); end
    n_checks++; if (get_adr(bt) !== 2'd2)     begin n_fail++; $display("FAIL glitch_next_adr: got %0h expected 2", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h3C)    begin n_fail++; $display("FAIL glitch_next_mod: got %02h expected 3c", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'hDEAD42) begin n_fail++; $display("FAIL glitch_next_d: got %06h expected dead42", get_d(bt)); end
    tick(20);
  endtask

  task automatic test_timeout;
    int bt, be;
    bt = trig_cnt; be = err_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(400);
    n_checks++; if (trig_cnt - bt !== 0) begin n_fail++; $display("FAIL timeout_trig_idle: got %0d expected 0", trig_cnt - bt); end
`ifdef USART_RX_TIMEOUT_EN
    n_checks++; if (err_cnt - be !== 1)  begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - be); end
    send_frame(40'h03_07_11_22_33);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 1)      begin n_fail++; $display("FAIL timeout_next_trig: got %0d expected 1", trig_cnt - bt); end
    n_checks++; if (get_adr(bt) !== 2'd3)     begin n_fail++; $display("FAIL timeout_next_adr: got %0h expected 3", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h07)    begin n_fail++; $display("FAIL timeout_next_mod: got %02h expected 07", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'h112233) begin n_fail++; $display("FAIL timeout_next_d: got %06h expected 112233", get_d(bt)); end
`else
    n_checks++; if (err_cnt - be !== 0)  begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 0", err_cnt - be); end
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 1)      begin n_fail++; $display("FAIL timeout_next_trig: got %0d expected 1", trig_cnt - bt); end
    n_checks++; if (get_adr(bt) !== 2'd1)     begin n_fail++; $display("FAIL timeout_next_adr: got %0h expected 1", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h22)    begin n_fail++; $display("FAIL timeout_next_mod: got %02h expected 22", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'h445566) begin n_fail++; $display("FAIL timeout_next_d: got %06h expected 445566", get_d(bt)); end
`endif
    tick(20);
  endtask

  task automatic test_reset_mid_frame;
    int bt;
    send_byte(8'h01, 1'b1);
    uart_rxd = 1'b0;
    tick(BPS);
    uart_rxd = 1'b0;
    tick(BPS);
    uart_rxd = 1'b1;
    tick(BPS / 2);
    sys_rst = 1'b1;
    #1;
    n_checks++; if (D !== 24'h0)        begin n_fail++; $display("FAIL midrst_d: got %06h expected 000000", D); end
    n_checks++; if (Adress !== 2'd0)    begin n_fail++; $display("FAIL midrst_adr: got %0h expected 0", Adress); end
    n_checks++; if (Mod_SEL !== 6'd0)   begin n_fail++; $display("FAIL midrst_mod: got %02h expected 00", Mod_SEL); end
    n_checks++; if (trig !== 1'b0)      begin n_fail++; $display("FAIL midrst_trig: got %0b expected 0", trig); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %0b expected 0", frame_err); end
    uart_rxd = 1'b1;
    tick(3);
    sys_rst = 1'b0;
    tick(20);
    bt = trig_cnt;
    send_frame(40'h03_3F_01_02_03);
    tick(4);
    n_checks++; if (trig_cnt - bt !== 1)      begin n_fail++; $display("FAIL midrst_next_trig: got %0d expected 1", trig_cnt - bt); end
    n_checks++; if (get_adr(bt) !== 2'd3)     begin n_fail++; $display("FAIL midrst_next_adr: got %0h expected 3", get_adr(bt)); end
    n_checks++; if (get_mod(bt) !== 6'h3F)    begin n_fail++; $display("FAIL midrst_next_mod: got %02h expected 3f", get_mod(bt)); end
    n_checks++; if (get_d(bt) !== 24'h010203) begin n_fail++; $display("FAIL midrst_next_d: got %06h expected 010203", get_d(bt)); end
    n_checks++; if (trig_wide !== 0) begin n_fail++; $display("FAIL trig_width_end: got %0d wide pulses expected 0", trig_wide); end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_back_to_back;
    test_stop_error;
    test_start_glitch;
    test_timeout;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usart_frame_rx.md
# usart_frame_rx

Serial command receiver at the UART input of the board link. It samples `uart_rxd`, deserialises 8N1 bytes, and assembles each 5-byte command frame into the `Adress`, `Mod_SEL` and `D` fields. It then pulses `trig`. These outputs drive the `usart_trans` reply path directly, so each received command is echoed back to the host.

## Interface
- `BPS_CNT`, 16'd434, system clocks per bit period (50 MHz / 115200).
- `TIMEOUT_CNT`, 32'd8680, idle clocks allowed between bytes of one frame (20 bit periods); used only with `USART_RX_TIMEOUT_EN`.
- `sys_clk` in 1: system clock, rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `uart_rxd` in 1: serial line, idle high, asynchronous to `sys_clk`.
- `trig` out 1: one-cycle pulse when a complete frame has been latched.
- `D` out 24: frame bytes 3..5, with byte 3 as MSB.
- `Adress` out 2: frame byte 1, bits [1:0].
- `Mod_SEL` out 6: frame byte 2, bits [5:0].
- `frame_err` out 1: one-cycle pulse on a stop-bit error or an inter-byte timeout.

## Operation
- **Input synchroniser:** `uart_rxd` passes through 2 flops, both reset to 1. A third flop provides falling-edge detection.
- **Bit FSM states:** IDLE, START, DATA, STOP.
- **Bit counter:** `bit_cnt` counts 0..BPS_CNT-1. A sample point is `bit_cnt == BPS_CNT/2` (integer divide).
- **IDLE:** a falling edge on the synchronised line moves the FSM to START and clears `bit_cnt`.
- **START:** at the sample point, a line value of 0 moves to DATA with `bit_cnt` cleared. A value of 1 is a glitch; return to IDLE and record no byte.
- **DATA:** sample 8 bits, LSB first, one per bit period. After bit 7, move to STOP.
- **STOP:**
  - At the sample point, a line value of 1 asserts an internal `byte_valid` for 1 cycle.
  - A value of 0 pulses `frame_err`, discards the byte and resets the byte index to 0.
  - Either way, return to IDLE at that sample point. Rejoining half a bit early allows back-to-back bytes.
- **Frame assembler:** a byte index runs 0..4. Each `byte_valid` writes the byte into a shadow register:
  - index 0 → address shadow, bits [1:0]
  - index 1 → mode shadow, bits [5:0]
  - index 2/3/4 → D[23:16]/D[15:8]/D[7:0]
  - Unused upper bits are dropped.
- **Frame completion:** on the `byte_valid` at index 4, copy all shadows to the outputs, pulse `trig` and reset the index to 0.
- **Output stability:** outputs change only on frame completion. They hold their value between frames, so a partial frame never disturbs them.
- **Reset:** `sys_rst` clears the following at any time, including mid-byte or mid-frame:
  - FSM to IDLE
  - all counters and the byte index
  - all shadow registers
  - outputs: `trig`=0, `D`=0, `Adress`=0, `Mod_SEL`=0, `frame_err`=0

## Timing
- **Input latency:** 2 cycles of synchroniser latency before the FSM sees a line edge.
- **`trig` timing:** `trig` rises 1 cycle after the stop-bit sample of byte 5, and lasts exactly 1 cycle.
- **Output validity:** `D`, `Adress` and `Mod_SEL` update on the same edge that `trig` rises, so they are valid while `trig`=1.
- **`frame_err` timing:** `frame_err` fires 1 cycle after the offending stop sample, or 1 cycle after the timeout count is reached.
- **Throughput:** minimum frame spacing is 5 × 10 × BPS_CNT clocks. A frame may follow the stop bit of the previous one with no gap.
- **Sampling tolerance:** a start glitch shorter than BPS_CNT/2 clocks is rejected.

## Configuration
- **`USART_RX_TIMEOUT_EN` defined:**
  - A timer counts clocks while the byte index is nonzero and the FSM is in IDLE.
  - The timer clears on every `byte_valid`.
  - When the timer reaches TIMEOUT_CNT, the index resets to 0 and `frame_err` pulses.
  - If `byte_valid` and timer expiry occur in the same cycle, the byte wins: it is stored and the timer clears.
- **`USART_RX_TIMEOUT_EN` undefined:** no timer is built. A partial frame waits indefinitely for its remaining bytes.

## Test plan
Bench settings: BPS_CNT=16, TIMEOUT_CNT=320, ideal bit timing unless stated otherwise.
- **Basic frame:** send 0x02,0x15,0xAB,0xCD,0xEF → exactly one `trig` pulse; `Adress`=2, `Mod_SEL`=0x15, `D`=0xABCDEF; `frame_err` never asserts.
- **Width truncation and back-to-back frames:** send 0xFF,0xFF,0x00,0x00,0x01 immediately followed by 0x01,0x2A,0x12,0x34,0x56 → first `trig` gives `Adress`=3, `Mod_SEL`=0x3F, `D`=0x000001; second gives `Adress`=1, `Mod_SEL`=0x2A, `D`=0x123456.
- **Stop-bit error:** drive the 3rd byte's stop bit to 0 → one `frame_err` pulse, no `trig`, outputs unchanged; a following full frame 0x01,0x02,0x03,0x04,0x05 gives `D`=0x030405.
- **Start glitch:** a 5-clock low pulse on an idle line → no byte is recorded; a subsequent valid frame still decodes correctly.
- **Timeout (macro on):** send 2 bytes, idle for 400 clocks → `frame_err` pulse; the next 5 bytes form a complete frame. With the macro off, the same stimulus gives no `frame_err`, and `trig` fires after 3 more bytes.
- **Reset mid-frame:** assert `sys_rst` in the middle of byte 2 → all outputs read 0; after release, a full frame decodes correctly.
